// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Load encodings, bus widths and the EX->MEM bundle layout.
package mem_pkg;

  localparam int ES_MS_BUS_W  = 75;
  localparam int MS_WS_BUS_W  = 70;
  localparam int MS_FWD_BUS_W = 39;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  typedef struct packed {
    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and sign/zero extension.
// Misaligned halves use addr_lo[1] only; EX owns alignment faults.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_op,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    unique case (1'b1)
      (load_op == LD_B):  data = {{24{byte_sel[7]}}, byte_sel};
      (load_op == LD_H):  data = {{16{half_sel[15]}}, half_sel};
      (load_op == LD_BU): data = {24'h0, byte_sel};
      (load_op == LD_HU): data = {16'h0, half_sel};
      default:            data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: holds one instruction, waits for the data response,
// aligns load data and feeds WB plus the ID bypass/stall bus.
module mem_stage #(
  parameter int ES_MS_BUS_W  = mem_pkg::ES_MS_BUS_W,
  parameter int MS_WS_BUS_W  = mem_pkg::MS_WS_BUS_W,
  parameter int MS_FWD_BUS_W = mem_pkg::MS_FWD_BUS_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    ms_allowin,
  input  logic                    es_to_ms_valid,
  input  logic [ES_MS_BUS_W-1:0]  es_to_ms_bus,
  input  logic                    ws_allowin,
  output logic                    ms_to_ws_valid,
  output logic [MS_WS_BUS_W-1:0]  ms_to_ws_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic [MS_FWD_BUS_W-1:0] ms_fwd_bus
);

  import mem_pkg::*;

  logic                   ms_valid;
  logic [ES_MS_BUS_W-1:0] ms_bus_r;
  logic [31:0]            rdata_buf;
  logic                   rdata_buf_valid;

  es_ms_t      ms;
  logic        ms_ready_go;
  logic        ms_capture;
  logic        ms_leave;
  logic        ms_buffer;
  logic [31:0] eff_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        fwd_we;
  logic        fwd_blocked;

  assign ms = es_ms_t'(ms_bus_r);

  always_comb begin
    ms_ready_go    = !ms.mem_req || data_sram_data_ok
                   || rdata_buf_valid;
    ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid && ms_ready_go;
    ms_capture     = es_to_ms_valid && ms_allowin;
    ms_leave       = ms_to_ws_valid && ws_allowin;
    // Park a response WB cannot take yet; later pulses are ignored.
    ms_buffer      = data_sram_data_ok && ms_valid && ms.mem_req
                   && !rdata_buf_valid && !ws_allowin;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      ms_bus_r <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (ms_capture) ms_bus_r <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_buf       <= '0;
      rdata_buf_valid <= 1'b0;
    end else if (ms_capture || ms_leave) begin
      rdata_buf_valid <= 1'b0;
    end else if (ms_buffer) begin
      rdata_buf       <= data_sram_rdata;
      rdata_buf_valid <= 1'b1;
    end
  end

  assign eff_rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .rdata   (eff_rdata),
    .addr_lo (ms.alu_result[1:0]),
    .load_op (ms.load_op),
    .data    (load_data)
  );

  always_comb begin
    final_result = ms.res_from_mem ? load_data : ms.alu_result;
    fwd_we       = ms_valid && ms.gr_we && (ms.dest != 5'd0);
    fwd_blocked  = fwd_we && ms.res_from_mem && !ms_ready_go;
  end

  assign ms_to_ws_bus = {ms.gr_we, ms.dest, final_result, ms.pc};
  assign ms_fwd_bus   = {fwd_we, fwd_blocked, ms.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random
// traffic compared every cycle against an instruction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [38:0] ms_fwd_bus;

  int total = 0;
  int bad   = 0;

  // Model: the instruction held, whether its response arrived, and the data.
  logic        m_occ;
  logic        m_got;
  logic [31:0] m_resp;
  logic [74:0] m_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_fwd_bus        (ms_fwd_bus)
  );

  function automatic logic [74:0] mk(bit mr, bit rfm, logic [2:0] op,
    bit we, logic [4:0] d, logic [31:0] alu, logic [31:0] pc);
    return {mr, rfm, op, we, d, alu, pc};
  endfunction

  function automatic logic [31:0] ref_align(logic [31:0] rd,
    logic [1:0] a, logic [2:0] op);
    logic [31:0] v;
    int sh;
    case (op)
      3'd1, 3'd3: begin
        sh = 8 * int'(a);
        v = (rd >> sh) & 32'hFF;
        if (op == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end
      3'd2, 3'd4: begin
        sh = a[1] ? 16 : 0;
        v = (rd >> sh) & 32'hFFFF;
        if (op == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic chk(string name, logic [69:0] act, logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_occ  = 1'b0;
    m_got  = 1'b0;
    m_resp = '0;
    m_bus  = '0;
  endtask

  task automatic compare_model();
    logic        ready;
    logic [31:0] rd;
    logic [31:0] fin;
    logic        e_we;
    ready = !m_bus[74] || m_got || data_sram_data_ok;
    rd    = m_got ? m_resp : data_sram_rdata;
    fin   = m_bus[73] ? ref_align(rd, m_bus[33:32], m_bus[72:70])
                      : m_bus[63:32];
    e_we  = m_occ && m_bus[69] && (m_bus[68:64] != 5'd0);
    chk("allowin", ms_allowin, !m_occ || (ready && ws_allowin));
    chk("ws_valid", ms_to_ws_valid, m_occ && ready);
    if (m_occ && ready)
      chk("ws_bus", ms_to_ws_bus,
          {m_bus[69], m_bus[68:64], fin, m_bus[31:0]});
    chk("fwd_we", ms_fwd_bus[38], e_we);
    chk("fwd_blocked", ms_fwd_bus[37], e_we && m_bus[73] && !ready);
    if (e_we)
      chk("fwd_payload", ms_fwd_bus[36:0], {m_bus[68:64], fin});
  endtask

  task automatic update_model();
    logic ready;
    logic leave;
    logic allow;
    if (!resetn) begin
      model_clear();
      return;
    end
    ready = !m_bus[74] || m_got || data_sram_data_ok;
    leave = m_occ && ready && ws_allowin;
    allow = !m_occ || leave;
    if (es_to_ms_valid && allow) begin
      m_occ = 1'b1;
      m_bus = es_to_ms_bus;
      m_got = 1'b0;
    end else if (leave) begin
      m_occ = 1'b0;
      m_got = 1'b0;
    end else if (m_occ && m_bus[74] && !m_got && data_sram_data_ok) begin
      m_got  = 1'b1;
      m_resp = data_sram_rdata;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic do_load(logic [2:0] op, logic [31:0] addr,
    logic [31:0] rd, logic [31:0] expv, string nm);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1, 1, op, 1, 5'd7, addr, 32'h300);
    ws_allowin     = 1'b1;
    data_sram_data_ok = 1'b0;
    settle();
    advance();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    settle();
    chk({nm, "_valid"}, ms_to_ws_valid, 1);
    chk(nm, ms_to_ws_bus[63:32], expv);
    advance();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    model_clear();
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #2;
    settle();
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_ws_bus", ms_to_ws_bus, 0);
    chk("rst_fwd", ms_fwd_bus, 0);
    advance();
    resetn = 1'b1;

    // ALU op passes through in one cycle
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(0, 0, 3'd0, 1, 5'd5, 32'h1234, 32'h100);
    settle();
    advance();
    es_to_ms_valid = 1'b0;
    settle();
    chk("alu_valid", ms_to_ws_valid, 1);
    chk("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'h100});
    chk("alu_fwd", ms_fwd_bus, {1'b1, 1'b0, 5'd5, 32'h1234});
    advance();
    settle();
    chk("alu_gone", ms_to_ws_valid, 0);
    advance();

    do_load(3'd1, 32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80, "ld_b");
    do_load(3'd3, 32'h1003, 32'h80FF_FFFF, 32'h0000_0080, "ld_bu");
    do_load(3'd4, 32'h2002, 32'h8001_0000, 32'h0000_8001, "ld_hu");
    do_load(3'd2, 32'h2002, 32'h8001_0000, 32'hFFFF_8001, "ld_h");
    do_load(3'd0, 32'h2002, 32'h8001_0000, 32'h8001_0000, "ld_w");

    // Response held while WB stalls
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1, 1, 3'd0, 1, 5'd3, 32'h200, 32'h500);
    settle();
    advance();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    settle();
    chk("buf_allowin0", ms_allowin, 0);
    advance();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    settle();
    chk("buf_allowin1", ms_allowin, 0);
    chk("buf_hold1", ms_to_ws_bus[63:32], 32'h1234_5678);
    advance();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    settle();
    chk("buf_allowin2", ms_allowin, 0);
    chk("buf_spurious", ms_to_ws_bus[63:32], 32'h1234_5678);
    advance();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    ws_allowin        = 1'b1;
    settle();
    chk("buf_valid", ms_to_ws_valid, 1);
    chk("buf_data", ms_to_ws_bus[63:32], 32'h1234_5678);
    advance();

    // Load-use stall signal while waiting
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1, 1, 3'd0, 1, 5'd9, 32'h40, 32'h600);
    settle();
    advance();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("wait_blocked", ms_fwd_bus[37], 1);
      chk("wait_valid", ms_to_ws_valid, 0);
      advance();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    settle();
    chk("ok_blocked", ms_fwd_bus[37], 0);
    chk("ok_valid", ms_to_ws_valid, 1);
    advance();
    data_sram_data_ok = 1'b0;

    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(0, 0, 3'd0, 1, 5'd0, 32'h55, 32'h700);
    settle();
    advance();
    es_to_ms_valid = 1'b0;
    settle();
    chk("dest0_fwd_we", ms_fwd_bus[38], 0);
    chk("dest0_valid", ms_to_ws_valid, 1);
    advance();

    // Asynchronous reset while a load waits
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1, 1, 3'd0, 1, 5'd4, 32'h80, 32'h800);
    settle();
    advance();
    es_to_ms_valid = 1'b0;
    settle();
    chk("pre_rst_allowin", ms_allowin, 0);
    advance();
    resetn = 1'b0;
    model_clear();
    #1;
    chk("async_rst_allowin", ms_allowin, 1);
    data_sram_data_ok = 1'b1;
    #1;
    chk("async_rst_valid", ms_to_ws_valid, 0);
    settle();
    advance();
    resetn = 1'b1;
    settle();
    chk("orphan_ok", ms_to_ws_valid, 0);
    advance();
    data_sram_data_ok = 1'b0;

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      logic mr;
      mr = 1'($urandom_range(0, 1));
      es_to_ms_valid = 1'($urandom_range(0, 1));
      es_to_ms_bus   = mk(mr, mr && ($urandom_range(0, 3) != 0),
                          3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)),
                          $urandom, $urandom);
      ws_allowin        = ($urandom_range(0, 3) != 0);
      data_sram_data_ok = ($urandom_range(0, 2) == 0);
      data_sram_rdata   = $urandom;
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. Holds one instruction from EX, waits for the data-memory response of loads and stores, and aligns and sign- or zero-extends load data. It then presents the 70-bit {gr_we, dest, final_result, pc} bus to WB. It also drives a forwarding/stall bus back to ID for bypassing and load-use detection.

## Interface
Parameters:
- ES_MS_BUS_W, default 75: width of es_to_ms_bus.
- MS_WS_BUS_W, default 70: width of ms_to_ws_bus.
- MS_FWD_BUS_W, default 39: width of ms_fwd_bus.

Ports:
- clk  input  1  single clock; all state rises on posedge clk.
- resetn  input  1  reset, asynchronous, active-low. Clock and reset are fixed as stated here.
- ms_allowin  output  1  MEM can accept a new instruction this cycle.
- es_to_ms_valid  input  1  EX presents a valid instruction.
- es_to_ms_bus  input  75  bit layout, MSB to LSB:
  - mem_req[74]: load or store issued.
  - res_from_mem[73]: instruction is a load.
  - load_op[72:70]
  - gr_we[69]
  - dest[68:64]
  - alu_result[63:32]: result or byte address.
  - pc[31:0]
- ws_allowin  input  1  WB can accept.
- ms_to_ws_valid  output  1  MEM presents a valid, completed instruction.
- ms_to_ws_bus  output  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
- data_sram_data_ok  input  1  one-cycle pulse: the response to the oldest outstanding data request.
- data_sram_rdata  input  32  read data, valid only when data_ok is high.
- ms_fwd_bus  output  39  {fwd_we, fwd_blocked, fwd_dest[4:0], fwd_data[31:0]}.

## Operation
- State:
  - ms_valid
  - ms_bus_r (75 bits)
  - rdata_buf (32 bits)
  - rdata_buf_valid
- Capture: on the edge where es_to_ms_valid && ms_allowin, load ms_bus_r and clear rdata_buf_valid.
- ms_valid update: when ms_allowin, ms_valid <= es_to_ms_valid.
- Ready/go:
  - ms_ready_go = !mem_req || data_sram_data_ok || rdata_buf_valid.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Response buffering: if data_ok is high while ms_valid && mem_req && !rdata_buf_valid && !ws_allowin, store rdata into rdata_buf and set rdata_buf_valid.
  - rdata_buf_valid clears on the edge the instruction leaves (ms_to_ws_valid && ws_allowin).
- Effective read data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- data_ok received when !ms_valid, !mem_req, or rdata_buf_valid=1 is ignored. It must not alter any state.
- Load alignment uses a = alu_result[1:0]:
  - LD_W=000: full word.
  - LD_B=001: byte rdata[8a+7:8a], sign-extended.
  - LD_H=010: half rdata[16a[1]+15:16a[1]], sign-extended.
  - LD_BU=011: byte, zero-extended.
  - LD_HU=100: half, zero-extended.
  - Codes 101–111 yield the full word.
  - The misaligned half case a[0]=1 uses a[1] only; alignment exceptions belong to EX.
- final_result = res_from_mem ? aligned_load : alu_result.
- Forwarding bus:
  - fwd_we = ms_valid && gr_we && dest!=0.
  - fwd_blocked = fwd_we && res_from_mem && !ms_ready_go.
  - fwd_data = final_result.

## Timing
- Reset values:
  - ms_valid=0, rdata_buf_valid=0, rdata_buf=0, ms_bus_r=0.
  - Therefore ms_allowin=1, ms_to_ws_valid=0, ms_to_ws_bus=0, ms_fwd_bus=0.
- Latency: a non-memory instruction spends exactly 1 cycle in MEM.
- Memory instruction: it leaves on the first edge where data_ok (or the buffered response) and ws_allowin are both true. With data_ok in the capture+1 cycle and ws_allowin=1, latency is 1 cycle.
- Outputs are combinational from registered state plus data_ok/rdata. WB registers them.
- Simultaneous capture and leave: a back-to-back instruction is accepted on the same edge the current one leaves; rdata_buf_valid clears on that edge.
- Reset mid-operation: an asynchronous resetn drop clears all state immediately. A later orphan data_ok is ignored because ms_valid=0.

## Structure
- Shared package mem_pkg:
  - load_op encodings LD_W/LD_B/LD_H/LD_BU/LD_HU.
  - ES_MS_BUS_W, MS_WS_BUS_W, MS_FWD_BUS_W.
- One combinational sub-module, load_align: inputs (rdata[31:0], addr_lo[1:0], load_op[2:0]); output data[31:0]. All sequential logic stays in mem_stage.

## Test plan
- ALU op, alu_result=0x1234, dest=5, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x00001234,pc}; following cycle valid=0.
- LD_B at addr_lo=3, rdata=0x80FF_FFFF returned in capture+1 -> final_result=0xFFFF_FF80. LD_BU on the same data -> 0x0000_0080.
- LD_HU at addr_lo=2, rdata=0x8001_0000 -> 0x0000_8001. LD_H -> 0xFFFF_8001. LD_W -> 0x8001_0000.
- Load with data_ok=1, ws_allowin=0 for 3 cycles, rdata then changed to 0xDEAD_BEEF -> buffered value is delivered when ws_allowin=1. ms_allowin stays 0 throughout. A spurious data_ok during the wait is ignored.
- Load waiting 4 cycles for data_ok -> fwd_blocked=1 in each waiting cycle and 0 in the data_ok cycle. dest=0 -> fwd_we=0.
- resetn low while a load waits -> ms_valid=0 immediately. A data_ok after reset release produces no ms_to_ws_valid.
